im_boot_ctrl: RTL and testbench

//  Sequencer and single-port owner for the instruction memory (Giga_IM: async read, sync write, 512x32).

---
 rtl/im_boot_ctrl.sv | 119 +++++++++++
 tb/tb_im_boot_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_ctrl.sv
// Boot sequencer and sole owner of the instruction-memory port: optional zero-fill,
// program load from a valid/ready word stream, then hand-off to CPU fetch.
module im_boot_ctrl #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 512,
  parameter int CLEAR_ON_BOOT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] im_a,
  output logic              im_we,
  output logic [DATA_W-1:0] im_d,
  input  logic [DATA_W-1:0] im_spo,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  localparam state_t            BOOT_STATE = (CLEAR_ON_BOOT != 0) ? CLEAR : LOAD;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              handshake;

  assign handshake = (state == LOAD) && ld_valid && ld_ready;

  // The IM is async-read, so in RUN the fetch address must reach it combinationally.
  always_comb begin
    im_we = 1'b0;
    im_a  = ptr;
    im_d  = '0;
    if (state == RUN) begin
      im_a = fetch_pc;
    end else if (state == LOAD) begin
      im_d = ld_data;
    end
    if (!rst) begin
      im_we = (state == CLEAR) || handshake;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT_STATE;
      ptr         <= '0;
      load_count  <= '0;
      overflow    <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      cpu_stall   <= 1'b1;
      ld_ready    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            ptr      <= '0;
            state    <= LOAD;
            ld_ready <= 1'b1;
          end
        end

        LOAD: begin
          // Coming straight out of reset without a clear pass, ld_ready rises one cycle late.
          if (!ld_ready) begin
            ld_ready <= 1'b1;
          end else if (ld_valid) begin
            ptr <= ptr + 1'b1;
            if (load_count != FULL_COUNT) begin
              load_count <= load_count + 1'b1;
            end
            if (ld_last || (ptr == LAST_ADDR)) begin
              state     <= RUN;
              ld_ready  <= 1'b0;
              cpu_stall <= 1'b0;
              overflow  <= !ld_last;
            end
          end
        end

        RUN: begin
          if (reload) begin
            state       <= BOOT_STATE;
            ptr         <= '0;
            load_count  <= '0;
            overflow    <= 1'b0;
            cpu_stall   <= 1'b1;
            fetch_valid <= 1'b0;
            ld_ready    <= (BOOT_STATE == LOAD);
          end else begin
            fetch_valid <= fetch_en;
            if (fetch_en) begin
              fetch_instr <= im_spo;
            end
          end
        end

        default: begin
          state <= BOOT_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_boot_ctrl.sv
// Testbench for im_boot_ctrl: models the async-read IM, checks boot/clear/load/run
// behaviour with fixed vectors, hand-written corner sequences and random loads/fetches.
module tb_im_boot_ctrl;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reload = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] fetch_pc = '0;
  logic          fetch_en = 1'b0;
  logic [DW-1:0] fetch_instr;
  logic          fetch_valid;
  logic          cpu_stall;
  logic [AW-1:0] im_a;
  logic          im_we;
  logic [DW-1:0] im_d;
  logic [DW-1:0] im_spo;
  logic [AW:0]   load_count;
  logic          overflow;

  im_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_ON_BOOT(1)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_pc(fetch_pc), .fetch_en(fetch_en), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .cpu_stall(cpu_stall),
    .im_a(im_a), .im_we(im_we), .im_d(im_d), .im_spo(im_spo),
    .load_count(load_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Giga_IM stand-in: asynchronous read, synchronous write.
  logic [DW-1:0] im [DEPTH];
  assign im_spo = im[im_a];
  always @(posedge clk) if (im_we) im[im_a] <= im_d;

  int            wrAddr[$];
  logic [DW-1:0] wrData[$];
  int            badWe = 0;
  always @(negedge clk) begin
    if (im_we) begin
      wrAddr.push_back(int'(im_a));
      wrData.push_back(im_d);
      if (rst || !cpu_stall) badWe++;
    end
  end

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] expMem [DEPTH];
  logic [DW-1:0] modelInstr = '0;

  typedef struct {
    bit            en;
    logic [AW-1:0] pc;
    bit            expValid;
    logic [DW-1:0] expInstr;
  } fetch_vec_t;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int n);
    rst = 1'b1; reload = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
    repeat (n) tick();
    checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'd1);
    checkOutput("rst_ld_ready", 32'(ld_ready), 32'd0);
    checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    checkOutput("rst_fetch_instr", fetch_instr, 32'd0);
    checkOutput("rst_load_count", 32'(load_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    modelInstr = '0;
    rst = 1'b0;
  endtask

  // Expects exactly DEPTH zero writes at ascending addresses, then ld_ready.
  task automatic runClear();
    int stallBad = 0;
    int bad = 0;
    wrAddr.delete(); wrData.delete();
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (cpu_stall !== 1'b1) stallBad++;
      if (i == DEPTH - 1) checkOutput("clear_ld_ready_early", 32'(ld_ready), 32'd0);
    end
    checkOutput("clear_ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("clear_stall", 32'(stallBad), 32'd0);
    checkOutput("clear_writes", 32'(wrAddr.size()), 32'(DEPTH));
    for (int i = 0; i < wrAddr.size(); i++)
      if (wrAddr[i] != i || wrData[i] !== '0) bad++;
    for (int i = 0; i < DEPTH; i++) begin
      if (im[i] !== '0) bad++;
      expMem[i] = '0;
    end
    checkOutput("clear_content", 32'(bad), 32'd0);
  endtask

  task automatic loadWords(input logic [DW-1:0] words[$], input bit markLast, input int gapPct,
                           output int accepted);
    bit hs;
    int budget;
    accepted = 0;
    wrAddr.delete(); wrData.delete();
    for (int i = 0; i < words.size(); i++) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gapPct; g++) begin
        ld_valid = 1'b0;
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = words[i];
      ld_last  = markLast && (i == words.size() - 1);
      budget   = 0;
      hs       = 1'b0;
      while (!hs && budget < 20) begin
        hs = ld_ready;
        tick();
        budget++;
      end
      if (!hs) break;
      accepted++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Reference: a stream ends at its ld_last word, or is cut off after DEPTH words.
  task automatic checkLoad(input string tag, input logic [DW-1:0] words[$], input bit markLast,
                           input int accepted);
    int  expAcc;
    bit  expOvf;
    int  bad = 0;
    expOvf = !(markLast && words.size() <= DEPTH);
    expAcc = expOvf ? DEPTH : words.size();
    for (int i = 0; i < expAcc; i++) expMem[i] = words[i];
    checkOutput({tag, "_accepted"}, 32'(accepted), 32'(expAcc));
    checkOutput({tag, "_load_count"}, 32'(load_count), 32'(expAcc));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    checkOutput({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    checkOutput({tag, "_writes"}, 32'(wrAddr.size()), 32'(expAcc));
    for (int i = 0; i < wrAddr.size(); i++) if (wrAddr[i] != i) bad++;
    for (int i = 0; i < DEPTH; i++) if (im[i] !== expMem[i]) bad++;
    checkOutput({tag, "_im_content"}, 32'(bad), 32'd0);
  endtask

  task automatic applyStimulus(input bit en, input logic [AW-1:0] pc);
    fetch_en = en;
    fetch_pc = pc;
    tick();
  endtask

  task automatic randomFetch(input int n, input int hi);
    bit            en;
    logic [AW-1:0] pc;
    for (int i = 0; i < n; i++) begin
      en = 1'($urandom_range(1));
      pc = $urandom_range(1) ? AW'($urandom_range(hi)) : AW'($urandom_range(DEPTH - 1));
      applyStimulus(en, pc);
      if (en) modelInstr = expMem[pc];
      checkOutput("rnd_fetch_valid", 32'(fetch_valid), 32'(en));
      checkOutput("rnd_fetch_instr", fetch_instr, modelInstr);
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] words[$];
    fetch_vec_t    tbl[$];
    int            acc;
    int            n;

    for (int i = 0; i < DEPTH; i++) im[i] = $urandom;

    // Power-on: reset, full zero-fill
    applyReset(3);
    runClear();

    // Four-word program with gaps in ld_valid
    words = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
    loadWords(words, 1'b1, 50, acc);
    checkLoad("load4", words, 1'b1, acc);
    applyStimulus(1'b1, 9'd2);
    checkOutput("first_fetch_valid", 32'(fetch_valid), 32'd1);
    checkOutput("first_fetch_instr", fetch_instr, 32'hA0000002);

    // RUN fetch table: valid follows fetch_en one cycle later, instr holds when idle
    tbl.push_back('{1'b1, 9'd0,   1'b1, 32'hA0000000});
    tbl.push_back('{1'b0, 9'd1,   1'b0, 32'hA0000000});
    tbl.push_back('{1'b1, 9'd3,   1'b1, 32'hA0000003});
    tbl.push_back('{1'b1, 9'd2,   1'b1, 32'hA0000002});
    tbl.push_back('{1'b0, 9'd0,   1'b0, 32'hA0000002});
    tbl.push_back('{1'b1, 9'd1,   1'b1, 32'hA0000001});
    tbl.push_back('{1'b1, 9'd9,   1'b1, 32'h00000000});
    tbl.push_back('{1'b1, 9'd3,   1'b1, 32'hA0000003});
    tbl.push_back('{1'b1, 9'd511, 1'b1, 32'h00000000});
    tbl.push_back('{1'b0, 9'd3,   1'b0, 32'h00000000});
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].en, tbl[i].pc);
      checkOutput($sformatf("tbl%0d_valid", i), 32'(fetch_valid), 32'(tbl[i].expValid));
      checkOutput($sformatf("tbl%0d_instr", i), fetch_instr, tbl[i].expInstr);
    end
    fetch_en = 1'b0;
    modelInstr = 32'h00000000;

    // Reload from RUN, with a fetch request in the same cycle
    fetch_en = 1'b1; reload = 1'b1;
    tick();
    reload = 1'b0; fetch_en = 1'b0;
    checkOutput("reload_stall", 32'(cpu_stall), 32'd1);
    checkOutput("reload_fetch_valid", 32'(fetch_valid), 32'd0);
    checkOutput("reload_load_count", 32'(load_count), 32'd0);
    runClear();
    words.delete();
    n = $urandom_range(5, 40);
    for (int i = 0; i < n; i++) words.push_back($urandom);
    loadWords(words, 1'b1, 30, acc);
    checkLoad("reload_prog", words, 1'b1, acc);
    randomFetch(60, n + 3);

    // Overflow: 513 words, none marked last
    applyReset(2);
    runClear();
    words.delete();
    for (int i = 0; i < DEPTH + 1; i++) words.push_back($urandom);
    loadWords(words, 1'b0, 10, acc);
    checkLoad("ovf", words, 1'b0, acc);
    randomFetch(40, DEPTH - 1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    checkOutput("ovf_reload_overflow", 32'(overflow), 32'd0);
    checkOutput("ovf_reload_count", 32'(load_count), 32'd0);

    // reload held through CLEAR and LOAD is ignored; reset aborts a partial load
    applyReset(1);
    reload = 1'b1;
    runClear();
    words = '{32'h12345678, 32'h9ABCDEF0};
    loadWords(words, 1'b0, 0, acc);
    repeat (3) tick();
    checkOutput("midload_accepted", 32'(acc), 32'd2);
    checkOutput("midload_ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("midload_load_count", 32'(load_count), 32'd2);
    checkOutput("midload_stall", 32'(cpu_stall), 32'd1);
    applyReset(1);
    runClear();
    words = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002};
    loadWords(words, 1'b1, 20, acc);
    checkLoad("post_abort", words, 1'b1, acc);
    randomFetch(20, 5);

    checkOutput("we_outside_load", 32'(badWe), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
